mem_burst_responder: RTL and testbench

//   Memory-side end of the cache line-transfer interface: the responder to the

---
 rtl/mem_burst_responder_pkg.sv | 23 ++
 rtl/mem_burst_responder_if.sv | 26 ++
 rtl/mem_burst_responder_array.sv | 32 +++
 rtl/mem_burst_responder.sv | 125 ++++++++++++
 tb/tb_mem_burst_responder.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_burst_responder_pkg.sv
// Shared types and line geometry for the memory burst responder.
// Line offset width comes from `CACHE_B (4 when the build does not set it).
`ifndef CACHE_B
`define CACHE_B 4
`endif

package mem_resp_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATENCY,
        S_READ_BURST,
        S_WRITE_BURST
    } mem_resp_state_e;

    localparam int unsigned OFFSET_W   = `CACHE_B;
    localparam int unsigned BEAT_W     = OFFSET_W - 2;
    localparam int unsigned LINE_SIZE  = 2 ** BEAT_W;
    localparam int unsigned MEM_AW_DEF = 10;

    typedef logic [MEM_AW_DEF-1:0] word_idx_t;

endpackage

// File: rtl/mem_burst_responder_if.sv
// Cache line-transfer bus between the cache controller (master) and the
// memory-side burst responder (slave).
interface mem_burst_responder_if;

    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic        gnt_o;
    logic        wvalid_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        done_o;
    logic        err_o;

    modport master (
        output req_i, we_i, addr_i, wvalid_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, done_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wvalid_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, done_o, err_o
    );

endinterface

// File: rtl/mem_burst_responder_array.sv
// Word-wide main memory array: synchronous write, registered read.
// Storage is not reset; only the read-data register is.
module mem_resp_array #(
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic          i_re,
    input  logic          i_rzero,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [0:2**AW-1];
    logic [31:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // i_rzero substitutes zero data for a read of an out-of-range line
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   r_rdata <= '0;
        else if (i_re) r_rdata <= i_rzero ? '0 : r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_burst_responder.sv
// Memory-side responder for cache line fills and write-backs, one word per beat.
// Define MEM_ADDR_CHECK_EN to flag (err_o) and neutralise out-of-range bursts.
module mem_burst_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned OFFSET_WIDTH = OFFSET_W,
    parameter int unsigned MEM_AW       = 10,
    parameter int unsigned READ_LATENCY = 2
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    mem_burst_responder_if.slave bus
);

    localparam int unsigned BW     = OFFSET_WIDTH - 2;
    localparam int unsigned BASE_W = MEM_AW - BW;
    localparam int unsigned LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    mem_resp_state_e   r_state;
    logic [BASE_W-1:0] r_base;
    logic [BW-1:0]     r_beat;
    logic [LAT_W-1:0]  r_wait;
    logic              r_rvalid;
    logic              r_done;

    logic              w_gnt;
    logic              w_last;
    logic              w_we;
    logic              w_re;
    logic              w_drop;
    logic [MEM_AW-1:0] w_idx;
    logic              w_unused;

    assign w_gnt    = (r_state == S_IDLE);
    assign w_last   = (r_beat == '1);
    assign w_idx    = {r_base, r_beat};
    assign w_re     = (r_state == S_READ_BURST);
    assign w_we     = (r_state == S_WRITE_BURST) & bus.wvalid_i & ~w_drop;
    assign w_unused = ^{bus.addr_i[31:MEM_AW+2], bus.addr_i[OFFSET_WIDTH-1:0]};

`ifdef MEM_ADDR_CHECK_EN
    logic r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                  r_err <= 1'b0;
        else if (w_gnt & bus.req_i)   r_err <= |bus.addr_i[31:MEM_AW+2];
    end

    assign w_drop     = r_err;
    assign bus.err_o  = r_err;
`else
    assign w_drop     = 1'b0;
    assign bus.err_o  = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_base   <= '0;
            r_beat   <= '0;
            r_wait   <= '0;
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_done   <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_i) begin
                        r_base <= bus.addr_i[MEM_AW+1:OFFSET_WIDTH];
                        r_beat <= '0;
                        r_wait <= '0;
                        if (bus.we_i)                r_state <= S_WRITE_BURST;
                        else if (READ_LATENCY == 0)  r_state <= S_READ_BURST;
                        else                         r_state <= S_LATENCY;
                    end
                end
                S_LATENCY: begin
                    if (r_wait == LAT_W'(READ_LATENCY - 1)) begin
                        r_wait  <= '0;
                        r_state <= S_READ_BURST;
                    end else begin
                        r_wait  <= r_wait + 1'b1;
                    end
                end
                // beat counter wraps to zero on its own after the last beat
                S_READ_BURST: begin
                    r_rvalid <= 1'b1;
                    r_beat   <= r_beat + 1'b1;
                    if (w_last) begin
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                S_WRITE_BURST: begin
                    if (bus.wvalid_i) begin
                        r_beat <= r_beat + 1'b1;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.gnt_o    = w_gnt;
    assign bus.rvalid_o = r_rvalid;
    assign bus.done_o   = r_done;

    mem_resp_array #(.AW(MEM_AW)) u_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .i_we    (w_we),
        .i_waddr (w_idx),
        .i_wdata (bus.wdata_i),
        .i_re    (w_re),
        .i_rzero (w_drop),
        .i_raddr (w_idx),
        .o_rdata (bus.rdata_o)
    );

endmodule

// File: tb/tb_mem_burst_responder.sv
// Directed bench for mem_burst_responder: one READ_LATENCY=2 instance (a)
// and one READ_LATENCY=0 instance (b) sharing clock and reset.
module tb_mem_burst_responder;
    import mem_resp_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    logic [3:0][31:0] wb_data;
    logic [3:0][31:0] zero_line;
    logic [3:0][31:0] b_data;

    mem_burst_responder_if ifa ();
    mem_burst_responder_if ifb ();

    mem_burst_responder #(.MEM_AW(10), .READ_LATENCY(2)) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifa)
    );

    mem_burst_responder #(.MEM_AW(10), .READ_LATENCY(0)) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic hs(input bit sel, input logic we, input logic [31:0] addr);
        if (sel) begin ifb.req_i = 1'b1; ifb.we_i = we; ifb.addr_i = addr; end
        else     begin ifa.req_i = 1'b1; ifa.we_i = we; ifa.addr_i = addr; end
        step();
        if (sel) ifb.req_i = 1'b0;
        else     ifa.req_i = 1'b0;
    endtask

    task automatic wr(input bit sel, input logic [31:0] addr, input logic [3:0][31:0] d);
        hs(sel, 1'b1, addr);
        for (int i = 0; i < 4; i++) begin
            if (sel) begin ifb.wvalid_i = 1'b1; ifb.wdata_i = d[i]; end
            else     begin ifa.wvalid_i = 1'b1; ifa.wdata_i = d[i]; end
            step();
        end
        ifa.wvalid_i = 1'b0;
        ifb.wvalid_i = 1'b0;
        step();
    endtask

    task automatic rd(input bit sel, input logic [31:0] addr, output int lat,
                      output logic [3:0][31:0] data, output logic [3:0] rv,
                      output logic [3:0] dn, output logic rv_after, output logic dn_after);
        hs(sel, 1'b0, addr);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (sel ? ifb.rvalid_o : ifa.rvalid_o) begin
                lat = c - 1;
                break;
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            data[i] = sel ? ifb.rdata_o  : ifa.rdata_o;
            rv[i]   = sel ? ifb.rvalid_o : ifa.rvalid_o;
            dn[i]   = sel ? ifb.done_o   : ifa.done_o;
            step();
        end
        rv_after = sel ? ifb.rvalid_o : ifa.rvalid_o;
        dn_after = sel ? ifb.done_o   : ifa.done_o;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_chk++; if (ifa.gnt_o !== 1'b1)     $display("FAIL reset_gnt got %b want 1", ifa.gnt_o);      else n_pass++;
        n_chk++; if (ifa.rvalid_o !== 1'b0)  $display("FAIL reset_rvalid got %b want 0", ifa.rvalid_o); else n_pass++;
        n_chk++; if (ifa.rdata_o !== 32'h0)  $display("FAIL reset_rdata got %h want 0", ifa.rdata_o);  else n_pass++;
        n_chk++; if (ifa.done_o !== 1'b0)    $display("FAIL reset_done got %b want 0", ifa.done_o);    else n_pass++;
        n_chk++; if (ifa.err_o !== 1'b0)     $display("FAIL reset_err got %b want 0", ifa.err_o);      else n_pass++;
        n_chk++; if (ifb.gnt_o !== 1'b1)     $display("FAIL reset_gnt_b got %b want 1", ifb.gnt_o);    else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_back();
        hs(1'b0, 1'b1, 32'h0000_0040);
        n_chk++; if (ifa.gnt_o !== 1'b0) $display("FAIL wb_busy_gnt got %b want 0", ifa.gnt_o); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                ifa.wvalid_i = 1'b0;
                step();
                n_chk++; if (ifa.done_o !== 1'b0) $display("FAIL wb_gap_done got %b want 0", ifa.done_o); else n_pass++;
            end
            ifa.wvalid_i = 1'b1;
            ifa.wdata_i  = wb_data[i];
            if (i == 3) begin
                n_chk++; if (ifa.gnt_o !== 1'b0) $display("FAIL wb_last_gnt got %b want 0", ifa.gnt_o); else n_pass++;
            end
            step();
        end
        ifa.wvalid_i = 1'b0;
        n_chk++; if (ifa.done_o !== 1'b1) $display("FAIL wb_done got %b want 1", ifa.done_o); else n_pass++;
        n_chk++; if (ifa.gnt_o !== 1'b1)  $display("FAIL wb_done_gnt got %b want 1", ifa.gnt_o); else n_pass++;
        step();
        n_chk++; if (ifa.done_o !== 1'b0) $display("FAIL wb_done_pulse got %b want 0", ifa.done_o); else n_pass++;
    endtask

    task automatic test_fill();
        int lat;
        logic [3:0][31:0] d;
        logic [3:0] rv, dn;
        logic rva, dna;
        rd(1'b0, 32'h0000_0044, lat, d, rv, dn, rva, dna);
        n_chk++; if (lat !== 3) $display("FAIL fill_latency got %0d want 3", lat); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (d[i] !== wb_data[i]) $display("FAIL fill_data%0d got %h want %h", i, d[i], wb_data[i]); else n_pass++;
            n_chk++; if (rv[i] !== 1'b1) $display("FAIL fill_rvalid%0d got %b want 1", i, rv[i]); else n_pass++;
        end
        n_chk++; if (dn !== 4'b1000) $display("FAIL fill_done_beats got %b want 1000", dn); else n_pass++;
        n_chk++; if (rva !== 1'b0) $display("FAIL fill_rvalid_after got %b want 0", rva); else n_pass++;
        n_chk++; if (dna !== 1'b0) $display("FAIL fill_done_after got %b want 0", dna); else n_pass++;
    endtask

    task automatic test_req_held();
        int  hs_cnt;
        bit  found;
        hs_cnt = 0;
        found  = 1'b0;
        ifa.req_i  = 1'b1;
        ifa.we_i   = 1'b0;
        ifa.addr_i = 32'h0000_0044;
        for (int c = 0; c < 30; c++) begin
            if (ifa.done_o) begin found = 1'b1; break; end
            if (ifa.gnt_o) hs_cnt++;
            step();
        end
        n_chk++; if (found !== 1'b1) $display("FAIL held_done_seen got %b want 1", found); else n_pass++;
        n_chk++; if (hs_cnt !== 1)   $display("FAIL held_handshakes got %0d want 1", hs_cnt); else n_pass++;
        n_chk++; if (ifa.gnt_o !== 1'b1) $display("FAIL held_gnt_in_done got %b want 1", ifa.gnt_o); else n_pass++;
        step();
        ifa.req_i = 1'b0;
        n_chk++; if (ifa.gnt_o !== 1'b0) $display("FAIL held_second_accept got %b want 0", ifa.gnt_o); else n_pass++;
        found = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (ifa.done_o) begin found = 1'b1; break; end
            step();
        end
        n_chk++; if (found !== 1'b1) $display("FAIL held_second_done got %b want 1", found); else n_pass++;
        step();
    endtask

    task automatic test_rl0();
        int lat;
        logic [3:0][31:0] d;
        logic [3:0] rv, dn;
        logic rva, dna;
        wr(1'b1, 32'h0000_0080, b_data);
        rd(1'b1, 32'h0000_0088, lat, d, rv, dn, rva, dna);
        n_chk++; if (lat !== 1) $display("FAIL rl0_latency got %0d want 1", lat); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (d[i] !== b_data[i]) $display("FAIL rl0_data%0d got %h want %h", i, d[i], b_data[i]); else n_pass++;
        end
        n_chk++; if (rv !== 4'b1111) $display("FAIL rl0_rvalid got %b want 1111", rv); else n_pass++;
        n_chk++; if (dn !== 4'b1000) $display("FAIL rl0_done got %b want 1000", dn); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [3:0][31:0] d;
        logic [3:0] rv, dn;
        logic rva, dna;
        bit seen;
        hs(1'b0, 1'b0, 32'h0000_0044);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (ifa.rvalid_o) begin seen = 1'b1; break; end
            step();
        end
        step();
        n_chk++; if ((seen && ifa.rvalid_o) !== 1'b1) $display("FAIL mid_beat1_valid got %b want 1", ifa.rvalid_o); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_chk++; if (ifa.rvalid_o !== 1'b0) $display("FAIL mid_rst_rvalid got %b want 0", ifa.rvalid_o); else n_pass++;
        n_chk++; if (ifa.gnt_o !== 1'b1)    $display("FAIL mid_rst_gnt got %b want 1", ifa.gnt_o);       else n_pass++;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        rd(1'b0, 32'h0000_0044, lat, d, rv, dn, rva, dna);
        n_chk++; if (lat !== 3) $display("FAIL mid_reread_latency got %0d want 3", lat); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (d[i] !== wb_data[i]) $display("FAIL mid_reread_data%0d got %h want %h", i, d[i], wb_data[i]); else n_pass++;
        end
    endtask

    task automatic test_addr_range();
        int lat;
        logic [3:0][31:0] d;
        logic [3:0][31:0] exp_d;
        logic [3:0] rv, dn;
        logic rva, dna;
        logic exp_err;
`ifdef MEM_ADDR_CHECK_EN
        exp_err = 1'b1;
        exp_d   = zero_line;
`else
        exp_err = 1'b0;
        exp_d   = b_data;
`endif
        wr(1'b0, 32'h0000_0000, b_data);
        rd(1'b0, 32'h8000_0000, lat, d, rv, dn, rva, dna);
        n_chk++; if (ifa.err_o !== exp_err) $display("FAIL range_err got %b want %b", ifa.err_o, exp_err); else n_pass++;
        n_chk++; if (rv !== 4'b1111) $display("FAIL range_rvalid got %b want 1111", rv); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (d[i] !== exp_d[i]) $display("FAIL range_data%0d got %h want %h", i, d[i], exp_d[i]); else n_pass++;
        end
        rd(1'b0, 32'h0000_0044, lat, d, rv, dn, rva, dna);
        n_chk++; if (ifa.err_o !== 1'b0) $display("FAIL range_err_cleared got %b want 0", ifa.err_o); else n_pass++;
        n_chk++; if (d[3] !== wb_data[3]) $display("FAIL range_after_data got %h want %h", d[3], wb_data[3]); else n_pass++;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        wb_data   = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000};
        b_data    = {32'h1234_00B3, 32'h1234_00B2, 32'h1234_00B1, 32'h1234_00B0};
        zero_line = '0;
        rst_n = 1'b0;
        ifa.req_i = 1'b0; ifa.we_i = 1'b0; ifa.addr_i = '0; ifa.wvalid_i = 1'b0; ifa.wdata_i = '0;
        ifb.req_i = 1'b0; ifb.we_i = 1'b0; ifb.addr_i = '0; ifb.wvalid_i = 1'b0; ifb.wdata_i = '0;

        test_reset();
        test_write_back();
        test_fill();
        test_req_held();
        test_rl0();
        test_reset_mid();
        test_addr_range();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
